// File: rtl/kozak_count_uart.sv
// Purpose : turns each accepted 8-bit count into two ASCII hex chars (plus CR LF when
//           KOZAK_TX_CRLF_EN is defined) and sends them on an 8N1 UART line, LSB first.
// Latency : accept on edge N -> start bit on tx and busy high from edge N; no backpressure,
//           one pending value is held during a message, later arrivals overwrite it and pulse drop.
// Ports   : clk, rst_n (async, active low), ena, count_in[7:0], count_valid -> tx, busy, drop.
// Macro   : KOZAK_TX_CRLF_EN adds 0x0D 0x0A after the two hex digits.
module kozak_count_uart #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] count_in,
  input  logic       count_valid,
  output logic       tx,
  output logic       busy,
  output logic       drop
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

`ifdef KOZAK_TX_CRLF_EN
  localparam int unsigned NCHARS = 4;
`else
  localparam int unsigned NCHARS = 2;
`endif

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [1:0]  CHAR_LAST = 2'(NCHARS - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  char_q, char_d;
  logic [7:0]  active_q, active_d;
  logic [7:0]  pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;

  logic        accept;
  logic        baud_last;
  logic [7:0]  cur_char;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
  endfunction

  function automatic logic [7:0] char_byte(input logic [7:0] val, input logic [1:0] idx);
    case (idx)
      2'd0:    return hex_char(val[7:4]);
      2'd1:    return hex_char(val[3:0]);
      2'd2:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      char_q     <= '0;
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      char_q     <= char_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    char_d     = char_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = 1'b0;
    accept     = ena & count_valid;
    baud_last  = (baud_q == BAUD_LAST);

    // Any arrival while a message is on the line lands in pending, including one on
    // the very edge the last stop bit ends; it is consumed below in that case.
    if (accept && (state_q != S_IDLE)) begin
      pend_d     = count_in;
      pend_vld_d = 1'b1;
      drop_d     = pend_vld_q;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_START;
          active_d = count_in;
          baud_d   = '0;
          bit_d    = '0;
          char_d   = '0;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          bit_d  = '0;
          if (char_q == CHAR_LAST) begin
            char_d = '0;
            // Pending value follows with no idle gap, busy stays high.
            if (pend_vld_d) begin
              state_d    = S_START;
              active_d   = pend_d;
              pend_vld_d = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            char_d  = char_q + 2'd1;
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the line changes on the accepting edge.
  always_comb begin
    cur_char = char_byte(active_d, char_d);
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_char[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign drop = drop_q;

endmodule

// File: tb/tb_kozak_count_uart.sv
module tb_kozak_count_uart;

  localparam int CPB = 4;
`ifdef KOZAK_TX_CRLF_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 2;
`endif
  localparam int MSG_LEN = NCH * 10 * CPB;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] count_in = 8'h00;
  logic       count_valid = 1'b0;
  logic       tx, busy, drop;

  int checks = 0;
  int failures = 0;

  kozak_count_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .count_in(count_in),
    .count_valid(count_valid), .tx(tx), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: expected line waveform as a queue of cycle values
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    string d;
    d = "0123456789ABCDEF";
    return d[n];
  endfunction

  function automatic logic [7:0] msg_char(input logic [7:0] v, input int i);
    if (i == 0) return hex_ascii(v[7:4]);
    if (i == 1) return hex_ascii(v[3:0]);
    if (i == 2) return 8'h0D;
    return 8'h0A;
  endfunction

  bit         wave[$];
  logic       m_pend_vld = 1'b0;
  logic [7:0] m_pend_val = 8'h00;
  logic       exp_tx = 1'b1;
  logic       exp_busy = 1'b0;
  logic       exp_drop = 1'b0;

  task automatic push_msg(input logic [7:0] v);
    for (int c = 0; c < NCH; c++) begin
      logic [7:0] ch;
      ch = msg_char(v, c);
      for (int b = 0; b < 10; b++) begin
        bit lv;
        lv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : ch[b-1];
        for (int k = 0; k < CPB; k++) wave.push_back(lv);
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave.delete();
      m_pend_vld <= 1'b0;
      exp_tx     <= 1'b1;
      exp_busy   <= 1'b0;
      exp_drop   <= 1'b0;
    end else begin : model_step
      logic acc, was_busy, pv, dr;
      logic [7:0] pval;
      acc      = ena & count_valid;
      was_busy = (wave.size() != 0);
      pv       = m_pend_vld;
      pval     = m_pend_val;
      dr       = 1'b0;
      if (was_busy) void'(wave.pop_front());
      if (was_busy && acc) begin
        dr   = pv;
        pv   = 1'b1;
        pval = count_in;
      end
      if (wave.size() == 0) begin
        if (was_busy && pv) begin
          push_msg(pval);
          pv = 1'b0;
        end else if (!was_busy && acc) begin
          push_msg(count_in);
        end
      end
      m_pend_vld <= pv;
      m_pend_val <= pval;
      exp_drop   <= dr;
      exp_tx     <= (wave.size() != 0) ? wave[0] : 1'b1;
      exp_busy   <= (wave.size() != 0);
    end
  end

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (tx !== exp_tx) begin
        failures++;
        $display("FAIL cycle_tx t=%0t actual=%b required=%b", $time, tx, exp_tx);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL cycle_busy t=%0t actual=%b required=%b", $time, busy, exp_busy);
      end
      checks++;
      if (drop !== exp_drop) begin
        failures++;
        $display("FAIL cycle_drop t=%0t actual=%b required=%b", $time, drop, exp_drop);
      end
    end
  end

  // ---------------- activity counters and a serial receiver
  int   busy_cnt = 0;
  int   busy_falls = 0;
  int   drop_cnt = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
      if (prev_busy === 1'b1 && busy === 1'b0) busy_falls <= busy_falls + 1;
      if (drop === 1'b1) drop_cnt <= drop_cnt + 1;
    end
    prev_busy <= busy;
  end

  int         rx_q[$];
  logic       rx_act = 1'b0;
  int         rx_ph = 0;
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act <= 1'b1;
        rx_ph  <= 0;
      end
    end else begin : rx_step
      int ph;
      int k;
      ph = rx_ph + 1;
      rx_ph <= ph;
      if (ph >= CPB + HALF && ((ph - HALF) % CPB) == 0) begin
        k = (ph - HALF) / CPB;
        if (k <= 8) begin
          rx_sh[k-1] <= tx;
        end else begin
          rx_q.push_back((tx === 1'b1) ? int'(rx_sh) : -1);
          rx_act <= 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers
  int exp_rx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    @(negedge clk);
    count_in    = v;
    count_valid = 1'b1;
    @(negedge clk);
    count_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic expect_msg(input logic [7:0] v);
    for (int c = 0; c < NCH; c++) exp_rx.push_back(int'(msg_char(v, c)));
  endtask

  task automatic check_rx(input string name, input int start);
    check({name, "_count"}, 32'(rx_q.size() - start), 32'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && (start + i) < rx_q.size(); i++)
      check({name, "_byte"}, 32'(rx_q[start+i]), 32'(exp_rx[i]));
  endtask

  // ---------------- directed sequence
  initial begin : stim
    int rs, bs, fs, ds;

    // Reset held: line idle
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_drop", {31'd0, drop}, 32'd0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_tx", {31'd0, tx}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_busy_cnt", 32'(busy_cnt), 32'd0);

    // Single message 0x3A
    rs = rx_q.size(); bs = busy_cnt;
    strobe(8'h3A);
    wait_idle("msg3a_idle");
    check("msg3a_nbytes", 32'(rx_q.size() - rs), 32'(NCH));
    check("msg3a_char0", 32'(rx_q[rs]), 32'h33);
    check("msg3a_char1", 32'(rx_q[rs+1]), 32'h41);
`ifdef KOZAK_TX_CRLF_EN
    check("msg3a_cr", 32'(rx_q[rs+2]), 32'h0D);
    check("msg3a_lf", 32'(rx_q[rs+3]), 32'h0A);
    check("msg3a_busy_cycles", 32'(busy_cnt - bs), 32'd160);
`else
    check("msg3a_busy_cycles", 32'(busy_cnt - bs), 32'd80);
`endif

    // 0x00 then 0xFF mid-message: back-to-back
    rs = rx_q.size(); bs = busy_cnt; fs = busy_falls; ds = drop_cnt;
    strobe(8'h00);
    repeat (20) @(negedge clk);
    strobe(8'hFF);
    wait_idle("b2b_idle");
    exp_rx.delete(); expect_msg(8'h00); expect_msg(8'hFF);
    check_rx("b2b_rx", rs);
    check("b2b_ff_char", 32'(rx_q[rs+NCH]), 32'h46);
    check("b2b_busy_cycles", 32'(busy_cnt - bs), 32'(2 * MSG_LEN));
    check("b2b_busy_falls", 32'(busy_falls - fs), 32'd1);
    check("b2b_drops", 32'(drop_cnt - ds), 32'd0);

    // 0x01, 0x02, 0x03 during one message: 0x02 is dropped
    rs = rx_q.size(); ds = drop_cnt;
    strobe(8'h01);
    repeat (10) @(negedge clk);
    strobe(8'h02);
    repeat (5) @(negedge clk);
    strobe(8'h03);
    wait_idle("ovw_idle");
    exp_rx.delete(); expect_msg(8'h01); expect_msg(8'h03);
    check_rx("ovw_rx", rs);
    check("ovw_drops", 32'(drop_cnt - ds), 32'd1);

    // ena low ignores strobes; dropping ena mid-message still completes it
    rs = rx_q.size(); bs = busy_cnt;
    ena = 1'b0;
    strobe(8'h55);
    repeat (20) @(negedge clk);
    check("ena0_busy_cycles", 32'(busy_cnt - bs), 32'd0);
    check("ena0_rx", 32'(rx_q.size() - rs), 32'd0);
    ena = 1'b1;
    strobe(8'h12);
    repeat (10) @(negedge clk);
    ena = 1'b0;
    wait_idle("ena_mid_idle");
    exp_rx.delete(); expect_msg(8'h12);
    check_rx("ena_mid_rx", rs);
    ena = 1'b1;

    // Accept on the edge the last stop bit ends: seamless follow-on, no drop
    rs = rx_q.size(); fs = busy_falls; ds = drop_cnt;
    strobe(8'h11);
    repeat (MSG_LEN - 2) @(negedge clk);
    strobe(8'h22);
    wait_idle("edge_idle");
    exp_rx.delete(); expect_msg(8'h11); expect_msg(8'h22);
    check_rx("edge_rx", rs);
    check("edge_busy_falls", 32'(busy_falls - fs), 32'd1);
    check("edge_drops", 32'(drop_cnt - ds), 32'd0);

    // Reset mid-DATA of 0xA5 ('A' bit1 is 0 on the line)
    strobe(8'hA5);
    repeat (9) @(negedge clk);
    check("pre_reset_tx", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_reset_tx", {31'd0, tx}, 32'd1);
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_drop", {31'd0, drop}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rs = rx_q.size();
    strobe(8'h7E);
    wait_idle("post_reset_idle");
    check("post_reset_char0", 32'(rx_q[rs]), 32'h37);
    check("post_reset_char1", 32'(rx_q[rs+1]), 32'h45);
    exp_rx.delete(); expect_msg(8'h7E);
    check_rx("post_reset_rx", rs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
